// File: rtl/i3c_bus_pattern_gen_if.sv
// Pattern generator bus bundle: controller
// requests in, SCL/SDA drive values out.
interface i3c_bus_pattern_gen_if #(
  parameter int CntW = 16
) ();
  logic            enable_i;
  logic            req_hdr_exit_i;
  logic            req_target_reset_i;
  logic [CntW-1:0] t_phase_i;
  logic            scl_o;
  logic            sda_o;
  logic            busy_o;
  logic            done_o;

  modport master (
    output enable_i, req_hdr_exit_i,
    output req_target_reset_i, t_phase_i,
    input  scl_o, sda_o, busy_o, done_o
  );

  modport slave (
    input  enable_i, req_hdr_exit_i,
    input  req_target_reset_i, t_phase_i,
    output scl_o, sda_o, busy_o, done_o
  );
endinterface

// File: rtl/i3c_bus_pattern_gen.sv
// I3C HDR Exit / Target Reset pattern generator.
// Plays a timer-paced SCL/SDA table, then releases.
module i3c_bus_pattern_gen #(
  parameter int CntW = 16
) (
  input logic clk_i,
  input logic rst_ni,
  i3c_bus_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_e;

  typedef enum logic {
    HDR_EXIT, TGT_RESET
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [4:0]      ph_q, ph_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] t_q, t_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [4:0]      last_ph;
  logic [4:0]      ph_nxt;

  // {scl, sda} for phase p of pattern k
  function automatic logic [1:0] pat(
    input kind_e k,
    input logic [4:0] p
  );
    logic [1:0] v;
    v = 2'b11;
    unique case (1'b1)
      (k == HDR_EXIT && p <= 5'd7):
        v = {1'b0, ~p[0]};
      (k == HDR_EXIT && p == 5'd8):
        v = 2'b10;
      (k == TGT_RESET && p <= 5'd14):
        v = {1'b0, ~p[0]};
      (k == TGT_RESET && p == 5'd16):
        v = 2'b10;
      default:
        v = 2'b11;
    endcase
    return v;
  endfunction

  assign last_ph = (kind_q == TGT_RESET)
                 ? 5'd17 : 5'd9;
  assign ph_nxt  = ph_q + 5'd1;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (!bus.enable_i) begin
      state_d = IDLE;
      ph_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_target_reset_i ||
              bus.req_hdr_exit_i) begin
            state_d = RUN;
            kind_d  = bus.req_target_reset_i
                    ? TGT_RESET : HDR_EXIT;
            t_d     = (bus.t_phase_i == '0)
                    ? CntW'(1) : bus.t_phase_i;
            ph_d    = '0;
            cnt_d   = '0;
            scl_d   = 1'b0;
            sda_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          busy_d = 1'b1;
          scl_d  = scl_q;
          sda_d  = sda_q;
          if (cnt_q == t_q - CntW'(1)) begin
            cnt_d = '0;
            if (ph_q == last_ph) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              scl_d   = 1'b1;
              sda_d   = 1'b1;
            end else begin
              ph_d = ph_nxt;
              {scl_d, sda_d} = pat(kind_q, ph_nxt);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      kind_q  <= HDR_EXIT;
      ph_q    <= '0;
      cnt_q   <= '0;
      t_q     <= CntW'(1);
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.scl_o  = scl_q;
  assign bus.sda_o  = sda_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_i3c_bus_pattern_gen.sv
// Directed bench for i3c_bus_pattern_gen.
// Pin vector is {busy, done, scl, sda}.
module tb_i3c_bus_pattern_gen;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  i3c_bus_pattern_gen_if #(.CntW(16)) bus ();

  i3c_bus_pattern_gen #(.CntW(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit [1:0] hdr_tab [10] = '{
    2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
    2'b00, 2'b01, 2'b00, 2'b10, 2'b11
  };

  bit [1:0] tgt_tab [18] = '{
    2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
    2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
    2'b01, 2'b00, 2'b01, 2'b00, 2'b01,
    2'b11, 2'b10, 2'b11
  };

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] pins();
    return {bus.busy_o, bus.done_o,
            bus.scl_o, bus.sda_o};
  endfunction

  task automatic play(
    input string tag,
    input bit    tgt,
    input bit    hdr,
    input int    tp,
    input int    inj,
    input int    stop_c
  );
    int       t;
    int       nph;
    int       n_busy;
    int       fl_lo;
    int       tr_lo;
    int       fl_hi;
    int       rs_hi;
    bit [1:0] e;
    logic     ps;
    logic     pd;
    t      = (tp == 0) ? 1 : tp;
    nph    = tgt ? 18 : 10;
    n_busy = 0;
    fl_lo  = 0;
    tr_lo  = 0;
    fl_hi  = 0;
    rs_hi  = 0;
    ps     = 1'b1;
    pd     = 1'b1;
    bus.t_phase_i          = 16'(tp);
    bus.req_target_reset_i = tgt;
    bus.req_hdr_exit_i     = hdr;
    @(negedge clk);
    bus.req_target_reset_i = 1'b0;
    bus.req_hdr_exit_i     = 1'b0;
    bus.t_phase_i          = 16'(tp + 5);
    for (int c = 1; c <= nph * t + 1; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= nph * t) begin
        e = tgt ? tgt_tab[(c - 1) / t]
                : hdr_tab[(c - 1) / t];
        chk(tag, 32'(pins()), {28'd0, 2'b10, e});
      end else begin
        chk({tag, "_done"}, 32'(pins()), 32'h7);
      end
      if (bus.busy_o) n_busy++;
      if (!bus.scl_o && !ps && pd != bus.sda_o)
        tr_lo++;
      if (!bus.scl_o && !ps && pd && !bus.sda_o)
        fl_lo++;
      if (bus.scl_o && ps && pd && !bus.sda_o)
        fl_hi++;
      if (bus.scl_o && ps && !pd && bus.sda_o)
        rs_hi++;
      ps = bus.scl_o;
      pd = bus.sda_o;
      bus.req_hdr_exit_i = (c == inj);
      if (c == stop_c) return;
    end
    bus.req_hdr_exit_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(pins()), 32'h3);
    chk({tag, "_busy"}, n_busy, nph * t);
    chk({tag, "_trlo"}, tr_lo, tgt ? 14 : 7);
    chk({tag, "_fllo"}, fl_lo, tgt ? 7 : 4);
    chk({tag, "_flhi"}, fl_hi, tgt ? 1 : 0);
    chk({tag, "_rshi"}, rs_hi, 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.enable_i           = 1'b1;
    bus.req_hdr_exit_i     = 1'b0;
    bus.req_target_reset_i = 1'b0;
    bus.t_phase_i          = '0;
    repeat (2) @(negedge clk);
    chk("in_reset", 32'(pins()), 32'h3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 32'(pins()), 32'h3);
    end

    play("hdr_t4", 1'b0, 1'b1, 4, 0, 0);
    play("tgt_t3", 1'b1, 1'b0, 3, 0, 0);
    play("both_t0", 1'b1, 1'b1, 0, 5, 0);
    repeat (2) begin
      @(negedge clk);
      chk("no_queue", 32'(pins()), 32'h3);
    end

    play("abort", 1'b0, 1'b1, 2, 0, 11);
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(pins()), 32'h3);
    bus.enable_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 32'(pins()), 32'h3);
    end
    play("hdr_t1", 1'b0, 1'b1, 1, 0, 0);

    play("rst", 1'b1, 1'b0, 2, 0, 21);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(pins()), 32'h3);
    @(negedge clk);
    chk("rst_hold", 32'(pins()), 32'h3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'(pins()), 32'h3);
    play("post_rst", 1'b0, 1'b1, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
